minmax_window_ctrl: RTL and testbench

Windowed min/max scheduler for the sequential-logic min/max datapath. It accepts a stream of signed samples over a valid/ready handshake and tracks the running minimum and maximum. After every WINDOW accepted samples, or on an explicit flush, it emits one result record and clears its accumulators for the next window. It sits between a sample producer and a result consumer and removes the idle tick a bare running min/max tracker needs between a clear and its first sample.

---
 rtl/minmax_window_ctrl.sv | 104 ++++++++++
 tb/tb_minmax_window_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/minmax_window_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | minmax_window_ctrl                                                         |
// | Windowed signed min/max tracker: one result record per WINDOW samples or   |
// | per flush, emitted over a valid/ready handshake.                           |
// | Revision: 1.0                                                              |
// +---------------------------------------------------------------------------+
module minmax_window_ctrl #(
   parameter  int WIDTH  = 32,
   parameter  int WINDOW = 4,
   localparam int CW     = $clog2(WINDOW + 1)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   input  logic signed [WIDTH-1:0] in_num,
   output logic                    in_ready,
   input  logic                    flush,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [WIDTH-1:0] out_min,
   output logic signed [WIDTH-1:0] out_max,
   output logic        [CW-1:0]    out_count
);

   localparam logic [CW-1:0] C_WINDOW = CW'(WINDOW);

   typedef enum logic [0:0] {
      S_COLLECT = 1'b0,
      S_EMIT    = 1'b1
   } state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic        [CW-1:0]    r_cnt;
   logic signed [WIDTH-1:0] r_acc_min;
   logic signed [WIDTH-1:0] r_acc_max;
   logic signed [WIDTH-1:0] r_out_min;
   logic signed [WIDTH-1:0] r_out_max;
   logic        [CW-1:0]    r_out_count;

   logic                    w_accept;
   logic                    w_first;
   logic                    w_close;
   logic        [CW-1:0]    w_cnt_inc;
   logic signed [WIDTH-1:0] w_min_cand;
   logic signed [WIDTH-1:0] w_max_cand;

   assign in_ready  = rst && (r_state == S_COLLECT);
   assign out_valid = (r_state == S_EMIT);
   assign out_min   = r_out_min;
   assign out_max   = r_out_max;
   assign out_count = r_out_count;

   // The first sample of a window seeds both accumulators, so stale values never compete.
   always_comb begin
      w_accept    = in_valid && in_ready;
      w_first     = (r_cnt == '0);
      w_cnt_inc   = r_cnt + CW'(1);
      w_min_cand  = (w_first || (in_num < r_acc_min)) ? in_num : r_acc_min;
      w_max_cand  = (w_first || (in_num > r_acc_max)) ? in_num : r_acc_max;
      w_close     = 1'b0;
      w_state_nxt = r_state;
      case (r_state)
         S_COLLECT: begin
            w_close = (w_accept && (w_cnt_inc == C_WINDOW)) ||
                      (flush && (!w_first || w_accept));
            if (w_close) w_state_nxt = S_EMIT;
         end
         S_EMIT: begin
            if (out_ready) w_state_nxt = S_COLLECT;
         end
         default: w_state_nxt = S_COLLECT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= S_COLLECT;
         r_cnt       <= '0;
         r_acc_min   <= '0;
         r_acc_max   <= '0;
         r_out_min   <= '0;
         r_out_max   <= '0;
         r_out_count <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_acc_min <= w_min_cand;
            r_acc_max <= w_max_cand;
            r_cnt     <= w_cnt_inc;
         end
         // A sample accepted alongside flush belongs to the closing record.
         if (w_close) begin
            r_out_min   <= w_accept ? w_min_cand : r_acc_min;
            r_out_max   <= w_accept ? w_max_cand : r_acc_max;
            r_out_count <= w_accept ? w_cnt_inc  : r_cnt;
         end
         if (out_valid && out_ready) r_cnt <= '0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_minmax_window_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_minmax_window_ctrl                                                      |
// | Directed self-checking bench for minmax_window_ctrl (WIDTH=32, WINDOW=4).  |
// | Revision: 1.0                                                              |
// +---------------------------------------------------------------------------+
module tb_minmax_window_ctrl;

   localparam int WIDTH  = 32;
   localparam int WINDOW = 4;
   localparam int CW     = $clog2(WINDOW + 1);

   logic                    clk;
   logic                    rst;
   logic                    in_valid;
   logic signed [WIDTH-1:0] in_num;
   logic                    in_ready;
   logic                    flush;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [WIDTH-1:0] out_min;
   logic signed [WIDTH-1:0] out_max;
   logic        [CW-1:0]    out_count;

   int n_cmp;
   int n_err;

   minmax_window_ctrl #(
      .WIDTH  (WIDTH),
      .WINDOW (WINDOW)
   ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_num    (in_num),
      .in_ready  (in_ready),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_min   (out_min),
      .out_max   (out_max),
      .out_count (out_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic feed(input logic [31:0] v);
      in_valid = 1'b1;
      in_num   = v;
      tick();
      in_valid = 1'b0;
   endtask

   // Checks a pending record and, when out_ready is high, consumes it.
   task automatic chk_rec(input string tag, input logic [31:0] mn, input logic [31:0] mx,
                          input logic [31:0] cnt);
      chk({tag, ".valid"}, 32'(out_valid), 32'd1);
      chk({tag, ".min"},   out_min, mn);
      chk({tag, ".max"},   out_max, mx);
      chk({tag, ".count"}, 32'(out_count), cnt);
      chk({tag, ".rdy"},   32'(in_ready), 32'd0);
      tick();
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      #1;
   endtask

   initial begin
      n_cmp     = 0;
      n_err     = 0;
      rst       = 1'b0;
      in_valid  = 1'b0;
      in_num    = '0;
      flush     = 1'b0;
      out_ready = 1'b1;
      tick();
      tick();
      chk("rst.in_ready",  32'(in_ready), 32'd0);
      chk("rst.out_valid", 32'(out_valid), 32'd0);
      chk("rst.min",       out_min, 32'd0);
      chk("rst.max",       out_max, 32'd0);
      chk("rst.count",     32'(out_count), 32'd0);
      rst = 1'b1;
      #1;
      chk("rel.in_ready",  32'(in_ready), 32'd1);

      // First window after reset: reset value 0 must not be compared
      feed(7); feed(7); feed(7); feed(7);
      chk_rec("first7", 7, 7, 4);
      feed(-3); feed(-1); feed(-9); feed(-2);
      chk_rec("neg", -9, -1, 4);

      // Basic window, back-to-back
      feed(2); feed(1); feed(3);
      chk("basic.pre_valid", 32'(out_valid), 32'd0);
      feed(0);
      chk_rec("basic", 0, 3, 4);
      chk("basic.ready_back", 32'(in_ready), 32'd1);
      chk("basic.valid_drop", 32'(out_valid), 32'd0);

      // Backpressure: 100 is offered but must not be taken during EMIT
      out_ready = 1'b0;
      feed(5); feed(6); feed(7); feed(8);
      in_valid = 1'b1;
      in_num   = 100;
      for (int i = 0; i < 5; i++) chk_rec("bp", 5, 8, 4);
      out_ready = 1'b1;
      chk_rec("bp.release", 5, 8, 4);
      feed(100); feed(1); feed(2); feed(3);
      chk_rec("bp.next", 1, 100, 4);

      // Flush with no sample that cycle
      feed(5); feed(-7);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk_rec("flush2", -7, 5, 2);

      // Flush on an empty window is ignored
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush0.valid", 32'(out_valid), 32'd0);
      chk("flush0.ready", 32'(in_ready), 32'd1);

      // Flush coincident with an accepted sample
      feed(1); feed(2);
      flush = 1'b1;
      feed(9);
      flush = 1'b0;
      chk_rec("flush3", 1, 9, 3);

      // Reset mid-window discards the partial window
      feed(4); feed(5); feed(6);
      do_reset();
      chk("rstmid.valid", 32'(out_valid), 32'd0);
      chk("rstmid.min",   out_min, 32'd0);
      chk("rstmid.max",   out_max, 32'd0);
      chk("rstmid.count", 32'(out_count), 32'd0);
      feed(1); feed(2); feed(3); feed(4);
      chk_rec("rstmid.next", 1, 4, 4);

      // Reset during EMIT drops the pending record
      out_ready = 1'b0;
      feed(10); feed(20); feed(30); feed(40);
      chk("rstemit.pre", 32'(out_valid), 32'd1);
      do_reset();
      chk("rstemit.valid", 32'(out_valid), 32'd0);
      chk("rstemit.ready", 32'(in_ready), 32'd1);
      out_ready = 1'b1;
      feed(11); feed(12); feed(13); feed(14);
      chk_rec("rstemit.next", 11, 14, 4);

      // Extremes with random bubbles and junk data while idle
      begin
         logic [31:0] ext [4];
         ext[0] = 32'h7FFF_FFFF;
         ext[1] = 32'h8000_0000;
         ext[2] = 32'h0000_0000;
         ext[3] = 32'hFFFF_FFFF;
         for (int i = 0; i < 4; i++) begin
            int gap;
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
               in_num = $urandom;
               tick();
            end
            feed(ext[i]);
         end
      end
      chk_rec("extreme", 32'h8000_0000, 32'h7FFF_FFFF, 4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
